// File: rtl/ctrl_pkg.sv
// Shared opcodes, funct3 codes and sequencer state
// for the memory-stage control block.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  function automatic logic [3:0] store_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'hF;
    if (f3 == F3_B) begin
      be = 4'b0001 << a;
    end else if (f3 == F3_H) begin
      be = a[1] ? 4'b1100 : 4'b0011;
    end
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) begin
      m = a[0];
    end else if (f3 == F3_W) begin
      m = |a;
    end
    return m;
  endfunction

endpackage

// File: rtl/ld_align.sv
// Load-data lane select and sign/zero extension.
// Purely combinational; shared with writeback.
module ld_align
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      f3,
  input  logic [1:0]      a,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (a)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (f3 == F3_B):  data = {{(XLEN-8){b[7]}}, b};
      (f3 == F3_H):  data = {{(XLEN-16){h[15]}}, h};
      (f3 == F3_BU): data = {{(XLEN-8){1'b0}}, b};
      (f3 == F3_HU): data = {{(XLEN-16){1'b0}}, h};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/control_m.sv
// Memory-stage register and data-cache sequencer.
// MISALIGN_TRAP_EN: trap misaligned H/W accesses.
module control_m
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      E_out_op,
  input  logic [2:0]      E_out_f3,
  input  logic [4:0]      E_out_rd,
  input  logic [XLEN-1:0] E_alu_out,
  input  logic [XLEN-1:0] E_rs2_data,
  output logic [6:0]      M_out_op,
  output logic [2:0]      M_out_f3,
  output logic [4:0]      M_out_rd,
  output logic [XLEN-1:0] M_out_alu,
  output logic [XLEN-1:0] M_out_ldata,
`ifdef MISALIGN_TRAP_EN
  output logic            M_out_misalign,
`endif
  output logic            waiting,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-1:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  output logic [3:0]      dc_be,
  input  logic            dc_gnt,
  input  logic            dc_rvalid,
  input  logic [XLEN-1:0] dc_rdata
);

  logic [6:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  state_e          state_q, state_d;

  logic [1:0]      a;
  logic            is_ld;
  logic            is_st;
  logic            mem_op;
  logic            mem_go;
  logic [XLEN-1:0] ld_ext;

  assign a      = alu_q[1:0];
  assign is_ld  = (op_q == OP_LOAD);
  assign is_st  = (op_q == OP_STORE);
  assign mem_op = is_ld || is_st;

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis            = mem_op && misaligned(f3_q, a);
  assign mem_go         = mem_op && !mis;
  assign M_out_rd       = mis ? 5'd0 : rd_q;
  assign M_out_misalign = mis;
`else
  assign mem_go   = mem_op;
  assign M_out_rd = rd_q;
`endif

  assign waiting = mem_go && (state_q != ST_DONE);

  assign M_out_op    = op_q;
  assign M_out_f3    = f3_q;
  assign M_out_alu   = alu_q;
  assign M_out_ldata = ldata_q;

  ld_align #(
    .XLEN (XLEN)
  ) u_ld_align (
    .f3    (f3_q),
    .a     (a),
    .rdata (dc_rdata),
    .data  (ld_ext)
  );

  always_comb begin
    op_d  = op_q;
    f3_d  = f3_q;
    rd_d  = rd_q;
    alu_d = alu_q;
    rs2_d = rs2_q;
    if (!waiting) begin
      op_d  = E_out_op;
      f3_d  = E_out_f3;
      rd_d  = E_out_rd;
      alu_d = E_alu_out;
      rs2_d = E_rs2_data;
    end
  end

  always_comb begin
    ldata_d = ldata_q;
    if (state_q == ST_RESP && dc_rvalid && is_ld) begin
      ldata_d = ld_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    dc_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_go) begin
          dc_req  = 1'b1;
          state_d = dc_gnt ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        dc_req = 1'b1;
        if (dc_gnt) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (dc_rvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loads read the whole word and extract locally.
  always_comb begin
    dc_we    = is_st;
    dc_addr  = {alu_q[XLEN-1:2], 2'b00};
    dc_be    = is_st ? store_be(f3_q, a) : 4'hF;
    dc_wdata = rs2_q;
    if (f3_q == F3_B) begin
      dc_wdata = {4{rs2_q[7:0]}};
    end else if (f3_q == F3_H) begin
      dc_wdata = {2{rs2_q[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rs2_q   <= '0;
      ldata_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      op_q    <= op_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rs2_q   <= rs2_d;
      ldata_q <= ldata_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_control_m.sv
// Bench for control_m: reset corner, then a vector
// table through an expected-result queue.
module tb_control_m;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  E_out_op = '0;
  logic [2:0]  E_out_f3 = '0;
  logic [4:0]  E_out_rd = '0;
  logic [31:0] E_alu_out = '0;
  logic [31:0] E_rs2_data = '0;
  logic [6:0]  M_out_op;
  logic [2:0]  M_out_f3;
  logic [4:0]  M_out_rd;
  logic [31:0] M_out_alu;
  logic [31:0] M_out_ldata;
  logic        waiting;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_be;
  logic        dc_gnt = 1'b0;
  logic        dc_rvalid = 1'b0;
  logic [31:0] dc_rdata = '0;
`ifdef MISALIGN_TRAP_EN
  logic        M_out_misalign;
`endif

  always #5 clk = ~clk;

  control_m #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .E_out_op    (E_out_op),
    .E_out_f3    (E_out_f3),
    .E_out_rd    (E_out_rd),
    .E_alu_out   (E_alu_out),
    .E_rs2_data  (E_rs2_data),
    .M_out_op    (M_out_op),
    .M_out_f3    (M_out_f3),
    .M_out_rd    (M_out_rd),
    .M_out_alu   (M_out_alu),
    .M_out_ldata (M_out_ldata),
`ifdef MISALIGN_TRAP_EN
    .M_out_misalign (M_out_misalign),
`endif
    .waiting     (waiting),
    .dc_req      (dc_req),
    .dc_we       (dc_we),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_be       (dc_be),
    .dc_gnt      (dc_gnt),
    .dc_rvalid   (dc_rvalid),
    .dc_rdata    (dc_rdata)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gdly;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    int          nwait;
    logic [4:0]  xrd;
    logic        mis;
  } vec_t;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ADD = 7'b0110011;

  vec_t tv[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
    logic [31:0] alu, logic [31:0] rs2,
    logic [31:0] rdata, int gdly, logic req,
    logic we, logic [31:0] addr, logic [3:0] be,
    logic [31:0] wdata, logic [31:0] ldata,
    int nwait, logic [4:0] xrd, logic mis
  );
    vec_t v;
    v.op = op; v.f3 = f3; v.rd = rd;
    v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.gdly = gdly; v.req = req; v.we = we;
    v.addr = addr; v.be = be; v.wdata = wdata;
    v.ldata = ldata; v.nwait = nwait;
    v.xrd = xrd; v.mis = mis;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_e(input vec_t v);
    E_out_op   = v.op;
    E_out_f3   = v.f3;
    E_out_rd   = v.rd;
    E_alu_out  = v.alu;
    E_rs2_data = v.rs2;
  endtask

  task automatic clr_e();
    E_out_op   = '0;
    E_out_f3   = '0;
    E_out_rd   = '0;
    E_alu_out  = '0;
    E_rs2_data = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op"}, {25'd0, M_out_op}, 32'd0);
    chk({tag, "_rd"}, {27'd0, M_out_rd}, 32'd0);
    chk({tag, "_alu"}, M_out_alu, 32'd0);
    chk({tag, "_ldata"}, M_out_ldata, 32'd0);
    chk({tag, "_req"}, {31'd0, dc_req}, 32'd0);
    chk({tag, "_wait"}, {31'd0, waiting}, 32'd0);
  endtask

  // Ends on the negedge of the first non-waiting cycle,
  // so the next call lands on the DONE->IDLE edge.
  task automatic run(input vec_t v);
    vec_t e;
    int   nw;
    bit   done;
    set_e(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    clr_e();
    e = v;
    nw = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      dc_gnt    = v.req && (c == v.gdly);
      dc_rvalid = v.req && (c == v.gdly + 1);
      dc_rdata  = v.rdata;
      @(negedge clk);
      if (c == 0) begin
        e = sb.pop_front();
        chk("m_op", {25'd0, M_out_op}, {25'd0, e.op});
        chk("m_rd", {27'd0, M_out_rd}, {27'd0, e.xrd});
        chk("m_alu", M_out_alu, e.alu);
        chk("dc_req", {31'd0, dc_req}, {31'd0, e.req});
`ifdef MISALIGN_TRAP_EN
        chk("m_mis", {31'd0, M_out_misalign},
            {31'd0, e.mis});
`endif
        if (e.req) begin
          chk("dc_we", {31'd0, dc_we}, {31'd0, e.we});
          chk("dc_addr", dc_addr, e.addr);
          chk("dc_be", {28'd0, dc_be}, {28'd0, e.be});
          if (e.we) chk("dc_wdata", dc_wdata, e.wdata);
        end
      end else if (e.req && c <= e.gdly) begin
        chk("req_hold", {31'd0, dc_req}, 32'd1);
        chk("addr_hold", dc_addr, e.addr);
        chk("op_frozen", {25'd0, M_out_op},
            {25'd0, e.op});
      end
      if (waiting) begin
        nw++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    dc_gnt    = 1'b0;
    dc_rvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%h alu=%h", v.op, v.alu);
    end
    chk("nwait", nw, e.nwait);
    chk("ldata", M_out_ldata, e.ldata);
  endtask

  initial begin
    logic [31:0] lprev;

    tv.push_back(mk(ADD, 3'd0, 5'd1, 32'h5, 32'h0,
      32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0,
      32'h0, 0, 5'd1, 0));
    tv.push_back(mk(LD, 3'd2, 5'd2, 32'h100, 32'h0,
      32'hDEADBEEF, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      32'hDEADBEEF, 2, 5'd2, 0));
    tv.push_back(mk(LD, 3'd0, 5'd3, 32'h103, 32'h0,
      32'h80FFFFFF, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      32'hFFFFFF80, 2, 5'd3, 0));
    tv.push_back(mk(LD, 3'd4, 5'd4, 32'h103, 32'h0,
      32'h80FFFFFF, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      32'h00000080, 2, 5'd4, 0));
    tv.push_back(mk(ST, 3'd1, 5'd5, 32'h102,
      32'h1234ABCD, 32'h0, 0, 1, 1, 32'h100, 4'hC,
      32'hABCDABCD, 32'h00000080, 2, 5'd5, 0));
    tv.push_back(mk(ST, 3'd0, 5'd0, 32'h101,
      32'h000000A5, 32'h0, 1, 1, 1, 32'h100, 4'h2,
      32'hA5A5A5A5, 32'h00000080, 3, 5'd0, 0));
    tv.push_back(mk(ST, 3'd2, 5'd8, 32'h204,
      32'hCAFEF00D, 32'h0, 0, 1, 1, 32'h204, 4'hF,
      32'hCAFEF00D, 32'h00000080, 2, 5'd8, 0));
    tv.push_back(mk(LD, 3'd1, 5'd10, 32'h102, 32'h0,
      32'h80017FFF, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      32'hFFFF8001, 2, 5'd10, 0));
    tv.push_back(mk(LD, 3'd5, 5'd11, 32'h100, 32'h0,
      32'h1234F00F, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      32'h0000F00F, 2, 5'd11, 0));
    tv.push_back(mk(LD, 3'd0, 5'd12, 32'h100, 32'h0,
      32'h0000007F, 2, 1, 0, 32'h100, 4'hF, 32'h0,
      32'h0000007F, 4, 5'd12, 0));
    tv.push_back(mk(LD, 3'd3, 5'd13, 32'h108, 32'h0,
      32'h11223344, 0, 1, 0, 32'h108, 4'hF, 32'h0,
      32'h11223344, 2, 5'd13, 0));
    tv.push_back(mk(7'd0, 3'd0, 5'd0, 32'h77, 32'h0,
      32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0,
      32'h11223344, 0, 5'd0, 0));
    tv.push_back(mk(LD, 3'd2, 5'd14, 32'h300, 32'h0,
      32'h0BADF00D, 5, 1, 0, 32'h300, 4'hF, 32'h0,
      32'h0BADF00D, 7, 5'd14, 0));
    lprev = 32'h0BADF00D;
`ifdef MISALIGN_TRAP_EN
    tv.push_back(mk(LD, 3'd2, 5'd9, 32'h102, 32'h0,
      32'h55667788, 0, 0, 0, 32'h0, 4'h0, 32'h0,
      lprev, 0, 5'd0, 1));
    tv.push_back(mk(ST, 3'd1, 5'd6, 32'h101,
      32'h0000BEEF, 32'h0, 0, 0, 0, 32'h0, 4'h0,
      32'h0, lprev, 0, 5'd0, 1));
`else
    lprev = 32'h55667788;
    tv.push_back(mk(LD, 3'd2, 5'd9, 32'h102, 32'h0,
      32'h55667788, 0, 1, 0, 32'h100, 4'hF, 32'h0,
      lprev, 2, 5'd9, 0));
    tv.push_back(mk(ST, 3'd1, 5'd6, 32'h101,
      32'h0000BEEF, 32'h0, 0, 1, 1, 32'h100, 4'h3,
      32'hBEEFBEEF, lprev, 2, 5'd6, 0));
`endif
    tv.push_back(mk(LD, 3'd2, 5'd7, 32'h104, 32'h0,
      32'h13572468, 0, 1, 0, 32'h104, 4'hF, 32'h0,
      32'h13572468, 2, 5'd7, 0));

    #12;
    chk_zero("rst_in");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_out");

    // Reset arriving while the request sits ungranted.
    E_out_op  = LD;
    E_out_f3  = 3'd2;
    E_out_rd  = 5'd3;
    E_alu_out = 32'h40;
    @(posedge clk);
    #1;
    clr_e();
    @(negedge clk);
    chk("pre_rst_req", {31'd0, dc_req}, 32'd1);
    chk("pre_rst_wait", {31'd0, waiting}, 32'd1);
    @(posedge clk);
    #1;
    chk("req_state_req", {31'd0, dc_req}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dc_req}, 32'd0);
    chk("mid_rst_wait", {31'd0, waiting}, 32'd0);
    dc_gnt    = 1'b1;
    dc_rvalid = 1'b1;
    dc_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    dc_gnt    = 1'b0;
    dc_rvalid = 1'b0;
    @(negedge clk);
    chk_zero("post_rst");

    foreach (tv[i]) run(tv[i]);

    @(negedge clk);
    chk("final_req", {31'd0, dc_req}, 32'd0);
    chk("final_wait", {31'd0, waiting}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
